// File: rtl/sq_pipe_pkg.sv
// Shared constants and helpers for the chan_square_pipe datapath.
// Saturation in the top level is enabled by defining SQ_SAT_EN.
package sq_pipe_pkg;

    localparam logic MODE_SQUARE  = 1'b0;
    localparam logic MODE_PRODUCT = 1'b1;

    localparam int unsigned DEF_N     = 9;
    localparam int unsigned DEF_W     = 8;
    localparam int unsigned DEF_OUT_W = 8;
    localparam int unsigned DEF_LAT   = 3;

    // Reduce a product to out_w bits: all-ones on overflow when sat is set, else truncate.
    function automatic logic [31:0] sat_trunc(input logic [31:0]  prod,
                                              input int unsigned  out_w,
                                              input logic         ovf,
                                              input logic         sat);
        logic [31:0] mask;
        mask = (out_w >= 32) ? '1 : ((32'd1 << out_w) - 32'd1);
        return (sat && ovf) ? mask : (prod & mask);
    endfunction

endpackage

// File: rtl/mul_pipe.sv
// W x W unsigned multiplier with LAT enable-gated register stages.
// Stage 0 registers the full product; later stages only delay it.
module mul_pipe #(
    parameter int unsigned W   = 8,
    parameter int unsigned LAT = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] prod
);

    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] b_ext;
    logic [2*W-1:0] prod_q [LAT];

    assign a_ext = (2*W)'(a);
    assign b_ext = (2*W)'(b);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(LAT); i++) begin
                prod_q[i] <= '0;
            end
        end else if (en) begin
            prod_q[0] <= a_ext * b_ext;
            for (int i = 1; i < int'(LAT); i++) begin
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    assign prod = prod_q[LAT-1];

endmodule

// File: rtl/chan_square_pipe.sv
// N-channel pipelined squarer/multiplier with matched p delay and valid/ready flow control.
// Define SQ_SAT_EN to saturate overflowing channels to all-ones instead of truncating.
module chan_square_pipe
    import sq_pipe_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned W     = DEF_W,
    parameter int unsigned OUT_W = DEF_OUT_W,
    parameter int unsigned LAT   = DEF_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [N*W-1:0]     c_in,
    input  logic [N*W-1:0]     p_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*OUT_W-1:0] c_out,
    output logic [N*W-1:0]     p_out,
    output logic [N-1:0]       ovf
);

    logic           stall;
    logic           en;
    logic [LAT-1:0] valid_q;
    logic [N*W-1:0] p_q [LAT];

    assign out_valid = valid_q[LAT-1];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    // A stall freezes every stage, bubbles included, so beat spacing is preserved.
    assign en        = ~stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                p_q[i] <= '0;
            end
        end else if (en) begin
            valid_q[0] <= in_valid;
            p_q[0]     <= p_in;
            for (int i = 1; i < int'(LAT); i++) begin
                valid_q[i] <= valid_q[i-1];
                p_q[i]     <= p_q[i-1];
            end
        end
    end

    assign p_out = p_q[LAT-1];

    for (genvar k = 0; k < int'(N); k++) begin : g_ch
        logic [W-1:0]   op_a;
        logic [W-1:0]   op_b;
        logic [2*W-1:0] prod;

        assign op_a = c_in[k*W +: W];
        assign op_b = (mode == MODE_PRODUCT) ? p_in[k*W +: W] : op_a;

        mul_pipe #(
            .W   (W),
            .LAT (LAT)
        ) u_mul (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .a    (op_a),
            .b    (op_b),
            .prod (prod)
        );

        if (OUT_W >= 2*W) begin : g_no_ovf
            assign ovf[k] = 1'b0;
        end else begin : g_ovf
            assign ovf[k] = |prod[2*W-1:OUT_W];
        end

`ifdef SQ_SAT_EN
        assign c_out[k*OUT_W +: OUT_W] = OUT_W'(sat_trunc(32'(prod), OUT_W, ovf[k], 1'b1));
`else
        assign c_out[k*OUT_W +: OUT_W] = prod[OUT_W-1:0];
`endif
    end

endmodule

// File: tb/tb_chan_square_pipe.sv
// Directed self-checking bench for chan_square_pipe (N=9, W=8, LAT=3; OUT_W=8 and 16).
module tb_chan_square_pipe;

    localparam int unsigned N   = 9;
    localparam int unsigned W   = 8;
    localparam int unsigned LAT = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic           mode;
    logic [N*W-1:0] c_in;
    logic [N*W-1:0] p_in;
    logic           out_valid;
    logic           out_ready;
    logic [N*8-1:0] c_out;
    logic [N*W-1:0] p_out;
    logic [N-1:0]   ovf;

    logic            in_ready16;
    logic            out_valid16;
    logic [N*16-1:0] c_out16;
    logic [N*W-1:0]  p_out16;
    logic [N-1:0]    ovf16;

    int n_checks = 0;
    int n_errors = 0;

    chan_square_pipe #(.N(N), .W(W), .OUT_W(8), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .c_in(c_in), .p_in(p_in), .out_valid(out_valid), .out_ready(out_ready),
        .c_out(c_out), .p_out(p_out), .ovf(ovf)
    );

    chan_square_pipe #(.N(N), .W(W), .OUT_W(16), .LAT(LAT)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .mode(mode),
        .c_in(c_in), .p_in(p_in), .out_valid(out_valid16), .out_ready(out_ready),
        .c_out(c_out16), .p_out(p_out16), .ovf(ovf16)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fill(input logic [7:0] cv, input logic [7:0] pv);
        for (int k = 0; k < int'(N); k++) begin
            c_in[k*W +: W] = cv;
            p_in[k*W +: W] = pv;
        end
    endtask

    // Present one beat, then confirm it surfaces exactly LAT cycles later.
    task automatic run_beat(input string tag);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq({tag, "_lat1"}, 32'(out_valid), 0);
        tick();
        check_eq({tag, "_lat2"}, 32'(out_valid), 0);
        tick();
        check_eq({tag, "_lat3"}, 32'(out_valid), 1);
    endtask

    initial begin
        logic            seen;
        logic [N*8-1:0]  held;
        int              beat;
        int              exp_idx;

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0;
        c_in = '0; p_in = '0;

        // 1. Reset with random inputs
        for (int k = 0; k < int'(N); k++) begin
            c_in[k*W +: W] = 8'($urandom);
            p_in[k*W +: W] = 8'($urandom);
        end
        in_valid = 1'b1;
        mode     = 1'($urandom);
        repeat (3) tick();
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_c_out", 32'(|c_out), 0);
        check_eq("rst_p_out", 32'(|p_out), 0);
        check_eq("rst_ovf", 32'(ovf), 0);
        in_valid = 1'b0;
        rst = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            tick();
            seen |= out_valid;
        end
        check_eq("idle_no_valid", 32'(seen), 0);

        // 2. Square
        c_in = '0; p_in = '0; mode = 1'b0;
        c_in[0*W +: W] = 8'd3;
        c_in[8*W +: W] = 8'd15;
        p_in[0*W +: W] = 8'hA5;
        run_beat("sq");
        check_eq("sq_ch0", 32'(c_out[0 +: 8]), 9);
        check_eq("sq_ch8", 32'(c_out[64 +: 8]), 225);
        check_eq("sq_p0", 32'(p_out[0 +: 8]), 32'hA5);
        check_eq("sq_ovf", 32'(ovf), 0);
        tick();
        check_eq("sq_bubble", 32'(out_valid), 0);

        // 3. Product
        mode = 1'b1;
        fill(8'd5, 8'd7);
        run_beat("prod");
        for (int k = 0; k < int'(N); k++) begin
            check_eq($sformatf("prod_c%0d", k), 32'(c_out[k*8 +: 8]), 35);
            check_eq($sformatf("prod_p%0d", k), 32'(p_out[k*W +: W]), 7);
        end
        tick();

        // 4. Overflow: 20*20 = 400
        mode = 1'b0;
        fill(8'd20, 8'd0);
        run_beat("ovf");
`ifdef SQ_SAT_EN
        check_eq("ovf_c0", 32'(c_out[0 +: 8]), 255);
        check_eq("ovf_c8", 32'(c_out[64 +: 8]), 255);
`else
        check_eq("ovf_c0", 32'(c_out[0 +: 8]), 144);
        check_eq("ovf_c8", 32'(c_out[64 +: 8]), 144);
`endif
        check_eq("ovf_flags", 32'(ovf), 32'h1FF);
        check_eq("w16_valid", 32'(out_valid16), 1);
        check_eq("w16_c0", 32'(c_out16[0 +: 16]), 400);
        check_eq("w16_c8", 32'(c_out16[128 +: 16]), 400);
        check_eq("w16_ovf", 32'(ovf16), 0);
        check_eq("w16_p0", 32'(p_out16[0 +: 8]), 0);
        tick();

        // 5. Backpressure: beats 1..10, out_ready low for cycles 6..9
        beat = 1;
        exp_idx = 1;
        held = '0;
        for (int cy = 0; cy < 40; cy++) begin
            out_ready = !(cy >= 6 && cy < 10);
            in_valid  = (beat <= 10);
            fill(8'(beat), 8'(beat));
            #1;
            if (cy == 6) held = c_out;
            if (cy == 8) begin
                check_eq("bp_in_ready", 32'(in_ready), 0);
                check_eq("bp_w16_in_ready", 32'(in_ready16), 0);
                check_eq("bp_valid_held", 32'(out_valid), 1);
                check_eq("bp_c_held", 32'(c_out == held), 1);
            end
            if (out_valid && out_ready) begin
                if (exp_idx <= 10) begin
                    check_eq($sformatf("bp_c_%0d", exp_idx), 32'(c_out[0 +: 8]),
                             32'(exp_idx * exp_idx));
                    check_eq($sformatf("bp_p_%0d", exp_idx), 32'(p_out[3*W +: W]),
                             32'(exp_idx));
                end else begin
                    check_eq("bp_extra_beat", 32'(exp_idx), 10);
                end
                exp_idx++;
            end
            if (in_valid && in_ready) beat++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_eq("bp_count", 32'(exp_idx), 11);

        // 6. Reset mid-stream with three beats in flight
        mode = 1'b0;
        for (int b = 2; b <= 4; b++) begin
            fill(8'(b), 8'(b));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("mrst_valid", 32'(out_valid), 0);
        check_eq("mrst_c_out", 32'(|c_out), 0);
        repeat (2) tick();
        rst = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            tick();
            seen |= out_valid;
        end
        check_eq("mrst_flushed", 32'(seen), 0);
        fill(8'd6, 8'd9);
        run_beat("mrst_new");
        check_eq("mrst_new_c", 32'(c_out[0 +: 8]), 36);
        check_eq("mrst_new_p", 32'(p_out[0 +: 8]), 9);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
